// File: rtl/resync_cmd_decoder_if.sv
// Bundles the ReSync command line, channel mask and all decoded reset/calibration outputs.
// No storage; pure signal grouping. No backpressure: every output is a level or a one-cycle strobe.
interface resync_cmd_decoder_if #(
    parameter int NCH      = 2,
    parameter int CMD_BITS = 4,
    parameter int ERR_W    = 8
);
    logic                ReSync;
    logic [NCH-1:0]      ChMask;
    logic [NCH-1:0]      AdcRst_b;
    logic [NCH-1:0]      AdcCal;
    logic                DtuRst_b;
    logic                I2cRst_b;
    logic                AtuRst_b;
    logic                SyncPulse;
    logic                CmdValid;
    logic [CMD_BITS-1:0] CmdCode;
    logic                CmdErr;
    logic [ERR_W-1:0]    ErrCnt;

    modport master (
        output ReSync, ChMask,
        input  AdcRst_b, AdcCal, DtuRst_b, I2cRst_b, AtuRst_b,
        input  SyncPulse, CmdValid, CmdCode, CmdErr, ErrCnt
    );

    modport slave (
        input  ReSync, ChMask,
        output AdcRst_b, AdcCal, DtuRst_b, I2cRst_b, AtuRst_b,
        output SyncPulse, CmdValid, CmdCode, CmdErr, ErrCnt
    );
endinterface

// File: rtl/resync_cmd_decoder.sv
// Decodes framed ReSync commands (start, code MSB first, even parity) into stretched reset/cal pulses.
// Latency: strobes and pulse starts one cycle after the parity bit is sampled; all outputs registered.
// No backpressure: frames are accepted back-to-back with zero gap; retrigger reloads the full pulse length.
module resync_cmd_decoder #(
    parameter int NCH      = 2,
    parameter int CMD_BITS = 4,
    parameter int RST_LEN  = 8,
    parameter int CAL_LEN  = 4,
    parameter int ERR_W    = 8
) (
    input  logic                    clock,
    input  logic                    rst_b,
    resync_cmd_decoder_if.slave     bus
);
    localparam int RW = $clog2(RST_LEN + 1);
    localparam int CW = $clog2(CAL_LEN + 1);
    localparam int BW = $clog2(CMD_BITS + 1);
    // Reset counter slots: [NCH-1:0] ADC channels, then DTU, I2C, ATU.
    localparam int NRST = NCH + 3;
    localparam int I_DTU = NCH;
    localparam int I_I2C = NCH + 1;
    localparam int I_ATU = NCH + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
    logic [CMD_BITS-1:0]        shift_q, shift_d;
    logic [NRST-1:0][RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [NCH-1:0][CW-1:0]     cal_cnt_q, cal_cnt_d;
    logic                       cmd_valid_q, cmd_valid_d;
    logic                       cmd_err_q, cmd_err_d;
    logic                       sync_q, sync_d;
    logic [CMD_BITS-1:0]        cmd_code_q, cmd_code_d;
    logic [ERR_W-1:0]           err_cnt_q, err_cnt_d;

    logic [NRST-1:0]            ld_rst;
    logic [NCH-1:0]             ld_cal;
    logic [3:0]                 code_lo;
    logic                       hi_zero;
    logic                       par_ok;
    logic                       code_ok;
    logic [NCH-1:0]             adc_rst_b;
    logic [NCH-1:0]             adc_cal;

    // State register
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.ReSync) state_d = S_SHIFT;
            S_SHIFT:  if (bit_cnt_q == BW'(CMD_BITS - 1)) state_d = S_PARITY;
            S_PARITY: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign code_lo = shift_q[3:0];
    assign hi_zero = ((shift_q >> 4) == '0);
    // Even parity: the code bits plus the parity bit must hold an even number of ones.
    assign par_ok  = ~(^{shift_q, bus.ReSync});
    assign code_ok = hi_zero && (code_lo inside {[4'h1:4'h6], 4'hF});

    // Output/decode logic
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        sync_d      = 1'b0;
        ld_rst      = '0;
        ld_cal      = '0;
        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                shift_d   = '0;
            end
            S_SHIFT: begin
                bit_cnt_d = bit_cnt_q + BW'(1);
                shift_d   = {shift_q[CMD_BITS-2:0], bus.ReSync};
            end
            S_PARITY: begin
                if (par_ok && code_ok) begin
                    cmd_valid_d = 1'b1;
                    case (code_lo)
                        4'h1:    ld_rst[I_DTU] = 1'b1;
                        4'h2:    ld_rst[I_I2C] = 1'b1;
                        4'h3:    ld_rst[I_ATU] = 1'b1;
                        4'h4:    ld_rst[NCH-1:0] = bus.ChMask;
                        4'h5:    ld_cal = bus.ChMask;
                        4'h6:    sync_d = 1'b1;
                        4'hF:    ld_rst = '1;
                        default: ;
                    endcase
                end else begin
                    cmd_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pulse counters: a load always wins over the decrement, so retrigger never opens a gap.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        cal_cnt_d = cal_cnt_q;
        for (int i = 0; i < NRST; i++) begin
            if (ld_rst[i]) begin
                rst_cnt_d[i] = RW'(RST_LEN);
            end else if (rst_cnt_q[i] != '0) begin
                rst_cnt_d[i] = rst_cnt_q[i] - RW'(1);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (ld_cal[i]) begin
                cal_cnt_d[i] = CW'(CAL_LEN);
            end else if (cal_cnt_q[i] != '0) begin
                cal_cnt_d[i] = cal_cnt_q[i] - CW'(1);
            end
        end
    end

    always_comb begin
        cmd_code_d = cmd_valid_d ? shift_q : cmd_code_q;
        err_cnt_d  = err_cnt_q;
        if (cmd_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rst_cnt_q   <= {NRST{RW'(RST_LEN)}};
            cal_cnt_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            sync_q      <= 1'b0;
            cmd_code_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rst_cnt_q   <= rst_cnt_d;
            cal_cnt_q   <= cal_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            sync_q      <= sync_d;
            cmd_code_q  <= cmd_code_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        adc_rst_b = '0;
        adc_cal   = '0;
        for (int i = 0; i < NCH; i++) begin
            adc_rst_b[i] = (rst_cnt_q[i] == '0);
            adc_cal[i]   = (cal_cnt_q[i] != '0);
        end
    end

    assign bus.AdcRst_b  = adc_rst_b;
    assign bus.AdcCal    = adc_cal;
    assign bus.DtuRst_b  = (rst_cnt_q[I_DTU] == '0);
    assign bus.I2cRst_b  = (rst_cnt_q[I_I2C] == '0);
    assign bus.AtuRst_b  = (rst_cnt_q[I_ATU] == '0);
    assign bus.SyncPulse = sync_q;
    assign bus.CmdValid  = cmd_valid_q;
    assign bus.CmdCode   = cmd_code_q;
    assign bus.CmdErr    = cmd_err_q;
    assign bus.ErrCnt    = err_cnt_q;

endmodule

// File: tb/tb_resync_cmd_decoder.sv
// Directed bench for resync_cmd_decoder: frames are driven on the falling edge, outputs sampled on it.
module tb_resync_cmd_decoder;
    localparam int NCH = 2;

    logic clock = 1'b0;
    logic rst_b;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;
    int   act_n [7];
    int   runs  [7];
    int   n_valid, n_err, n_sync;

    always #3 clock = ~clock;

    resync_cmd_decoder_if #(.NCH(NCH), .CMD_BITS(4), .ERR_W(8)) bus ();

    resync_cmd_decoder #(
        .NCH(NCH), .CMD_BITS(4), .RST_LEN(8), .CAL_LEN(4), .ERR_W(8)
    ) dut (
        .clock (clock),
        .rst_b (rst_b),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Indices: 0 DTU, 1 I2C, 2 ATU, 3 ADC0 rst, 4 ADC1 rst, 5 ADC0 cal, 6 ADC1 cal.
    function automatic bit active(input int w);
        case (w)
            0:       return bus.DtuRst_b === 1'b0;
            1:       return bus.I2cRst_b === 1'b0;
            2:       return bus.AtuRst_b === 1'b0;
            3:       return bus.AdcRst_b[0] === 1'b0;
            4:       return bus.AdcRst_b[1] === 1'b0;
            5:       return bus.AdcCal[0] === 1'b1;
            default: return bus.AdcCal[1] === 1'b1;
        endcase
    endfunction

    // Samples every output for a fixed number of falling edges, starting at the current one.
    task automatic window(input int cycles);
        bit prev [7];
        bit a;
        for (int w = 0; w < 7; w++) begin
            act_n[w] = 0;
            runs[w]  = 0;
            prev[w]  = 1'b0;
        end
        n_valid = 0;
        n_err   = 0;
        n_sync  = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int w = 0; w < 7; w++) begin
                a = active(w);
                if (a) act_n[w]++;
                if (a && !prev[w]) runs[w]++;
                prev[w] = a;
            end
            if (bus.CmdValid === 1'b1) n_valid++;
            if (bus.CmdErr === 1'b1) n_err++;
            if (bus.SyncPulse === 1'b1) n_sync++;
            @(negedge clock);
        end
    endtask

    task automatic send_frame(input logic [3:0] code, input logic par);
        logic [5:0] f;
        f = {1'b1, code, par};
        for (int i = 5; i >= 0; i--) begin
            @(negedge clock);
            bus.ReSync = f[i];
        end
    endtask

    task automatic idle();
        @(negedge clock);
        bus.ReSync = 1'b0;
    endtask

    initial begin
        rst_b      = 1'b0;
        bus.ReSync = 1'b0;
        bus.ChMask = 2'b11;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_dtu_b", bus.DtuRst_b, 1'b0);
        chk("rst_i2c_b", bus.I2cRst_b, 1'b0);
        chk("rst_atu_b", bus.AtuRst_b, 1'b0);
        chk("rst_adc_b", bus.AdcRst_b, 2'b00);
        chk("rst_cal", bus.AdcCal, 2'b00);
        chk("rst_errcnt", bus.ErrCnt, 8'd0);
        chk("rst_code", bus.CmdCode, 4'd0);
        chk("rst_valid", bus.CmdValid, 1'b0);

        // Reset pulses last exactly RST_LEN cycles after release
        rst_b = 1'b1;
        window(12);
        chk("rel_dtu_len", act_n[0], 8);
        chk("rel_i2c_len", act_n[1], 8);
        chk("rel_atu_len", act_n[2], 8);
        chk("rel_adc0_len", act_n[3], 8);
        chk("rel_adc1_len", act_n[4], 8);
        chk("rel_cal_len", act_n[5] + act_n[6], 0);
        chk("rel_valid", n_valid, 0);

        // ADC reset on channel 1 only
        bus.ChMask = 2'b10;
        send_frame(4'h4, 1'b1);
        idle();
        chk("adc_valid", bus.CmdValid, 1'b1);
        chk("adc_code", bus.CmdCode, 4'h4);
        chk("adc_rst_b", bus.AdcRst_b, 2'b01);
        window(12);
        chk("adc1_len", act_n[4], 8);
        chk("adc0_untouched", act_n[3], 0);
        chk("adc_dtu_quiet", act_n[0], 0);
        chk("adc_valid_once", n_valid, 1);

        // Back-to-back DTU frames: the second reload extends the pulse without a gap
        bus.ChMask = 2'b11;
        fork
            window(24);
            begin
                send_frame(4'h1, 1'b1);
                send_frame(4'h1, 1'b1);
                idle();
            end
        join
        chk("retrig_dtu_len", act_n[0], 14);
        chk("retrig_dtu_runs", runs[0], 1);
        chk("retrig_valid", n_valid, 2);
        chk("retrig_adc_quiet", act_n[3] + act_n[4], 0);
        chk("retrig_code", bus.CmdCode, 4'h1);

        // Calibration on channel 0 only
        bus.ChMask = 2'b01;
        send_frame(4'h5, 1'b0);
        idle();
        chk("cal_code", bus.CmdCode, 4'h5);
        chk("cal_out", bus.AdcCal, 2'b01);
        window(8);
        chk("cal0_len", act_n[5], 4);
        chk("cal1_quiet", act_n[6], 0);

        // Bad parity, then unknown codes
        send_frame(4'h1, 1'b0);
        idle();
        chk("par_err", bus.CmdErr, 1'b1);
        chk("par_valid", bus.CmdValid, 1'b0);
        chk("par_errcnt", bus.ErrCnt, 8'd1);
        chk("par_code_held", bus.CmdCode, 4'h5);
        chk("par_dtu_b", bus.DtuRst_b, 1'b1);
        window(10);
        chk("par_dtu_quiet", act_n[0], 0);
        chk("par_err_once", n_err, 1);
        send_frame(4'h0, 1'b0);
        idle();
        chk("unk0_err", bus.CmdErr, 1'b1);
        chk("unk0_errcnt", bus.ErrCnt, 8'd2);
        send_frame(4'h7, 1'b1);
        idle();
        chk("unk7_err", bus.CmdErr, 1'b1);
        chk("unk7_valid", bus.CmdValid, 1'b0);
        chk("unk7_errcnt", bus.ErrCnt, 8'd3);
        chk("unk_code_held", bus.CmdCode, 4'h5);

        // Global reset ignores the channel mask
        bus.ChMask = 2'b00;
        send_frame(4'hF, 1'b0);
        idle();
        chk("glb_valid", bus.CmdValid, 1'b1);
        chk("glb_code", bus.CmdCode, 4'hF);
        window(10);
        chk("glb_dtu_len", act_n[0], 8);
        chk("glb_i2c_len", act_n[1], 8);
        chk("glb_atu_len", act_n[2], 8);
        chk("glb_adc0_len", act_n[3], 8);
        chk("glb_adc1_len", act_n[4], 8);
        chk("glb_sync_quiet", n_sync, 0);

        // Sync marker
        send_frame(4'h6, 1'b0);
        idle();
        chk("sync_pulse", bus.SyncPulse, 1'b1);
        chk("sync_code", bus.CmdCode, 4'h6);
        window(4);
        chk("sync_once", n_sync, 1);
        chk("sync_dtu_quiet", act_n[0], 0);

        // A masked channel keeps its running pulse while the other one is retriggered
        bus.ChMask = 2'b11;
        fork
            window(26);
            begin
                send_frame(4'h4, 1'b1);
                idle();
                bus.ChMask = 2'b10;
                send_frame(4'h4, 1'b1);
                idle();
            end
        join
        chk("mask_adc1_len", act_n[4], 15);
        chk("mask_adc1_runs", runs[4], 1);
        chk("mask_adc0_len", act_n[3], 8);
        chk("mask_adc0_runs", runs[3], 1);

        // Reset in the middle of a frame discards it
        @(negedge clock); bus.ReSync = 1'b1;
        @(negedge clock); bus.ReSync = 1'b0;
        @(negedge clock); bus.ReSync = 1'b0;
        @(negedge clock);
        rst_b      = 1'b0;
        bus.ReSync = 1'b0;
        @(negedge clock);
        chk("abort_errcnt", bus.ErrCnt, 8'd0);
        chk("abort_code", bus.CmdCode, 4'h0);
        chk("abort_dtu_b", bus.DtuRst_b, 1'b0);
        rst_b = 1'b1;
        window(14);
        chk("abort_no_valid", n_valid, 0);
        chk("abort_no_err", n_err, 0);
        chk("abort_dtu_len", act_n[0], 8);

        // Error counter saturates
        for (int k = 0; k < 256; k++) send_frame(4'h1, 1'b0);
        idle();
        chk("sat_err", bus.CmdErr, 1'b1);
        chk("sat_errcnt", bus.ErrCnt, 8'd255);
        @(negedge clock);
        chk("sat_errcnt_hold", bus.ErrCnt, 8'd255);
        chk("sat_err_off", bus.CmdErr, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
